// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_host_tx
// Brief    : PS/2 host-to-device command transmitter: clock inhibit,
//            request-to-send, 11-bit frame, device ACK and timeout, driven
//            open-drain via *_oe. Macro PS2_TX_RETRY_EN adds one retry.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2700,
    parameter int RTS_CYCLES     = 27,
    parameter int TIMEOUT_CYCLES = 405000
) (
    input  logic       CLOCK_27,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int c_MAX_A   = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int c_CNT_MAX = (TIMEOUT_CYCLES > c_MAX_A) ? TIMEOUT_CYCLES : c_MAX_A;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_INHIBIT_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_RTS_LAST     = c_CNT_W'(RTS_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_RTS     = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic               r_clk_meta, r_clk_sync, r_clk_prev;
    logic               r_dat_meta, r_dat_sync;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_bit_cnt;
    logic [9:0]         r_frame;
    logic               r_nack;
    logic               r_clk_oe, r_dat_oe, r_busy, r_done, r_error;

    logic w_clk_fall, w_wait_state, w_progress, w_timeout;
    logic w_release_done, w_fail, w_success, w_retry, w_accept;

    // Idle bus is high, so synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge CLOCK_27) begin
        if (reset) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk_in;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= ps2_dat_in;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign w_clk_fall     = r_clk_prev & ~r_clk_sync;
    assign w_accept       = (r_state == S_IDLE) & tx_start & ~r_done;
    assign w_wait_state   = (r_state == S_SEND) | (r_state == S_ACK) | (r_state == S_RELEASE);
    assign w_release_done = (r_state == S_RELEASE) & r_clk_sync & r_dat_sync;

    always_comb begin
        w_progress = 1'b0;
        case (r_state)
            S_SEND, S_ACK: w_progress = w_clk_fall;
            S_RELEASE:     w_progress = r_clk_sync & r_dat_sync;
            default:       w_progress = 1'b0;
        endcase
    end

    assign w_timeout = w_wait_state & ~w_progress & (r_cnt == c_TIMEOUT_LAST);
    assign w_fail    = w_timeout | (w_release_done & r_nack);
    assign w_success = w_release_done & ~r_nack;

`ifdef PS2_TX_RETRY_EN
    logic r_retry;

    always_ff @(posedge CLOCK_27) begin
        if (reset) begin
            r_retry <= 1'b0;
        end else if (w_accept) begin
            r_retry <= 1'b0;
        end else if (w_fail) begin
            r_retry <= 1'b1;
        end
    end

    assign w_retry = w_fail & ~r_retry;
`else
    assign w_retry = 1'b0;
`endif

    always_ff @(posedge CLOCK_27) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_frame   <= '0;
            r_nack    <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_dat_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        // Frame bits in transmit order: data LSB first, odd parity, stop.
                        r_frame   <= {1'b1, ~^tx_data, tx_data};
                        r_bit_cnt <= '0;
                        r_cnt     <= '0;
                        r_error   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_clk_oe  <= 1'b1;
                        r_dat_oe  <= 1'b0;
                        r_state   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (r_cnt == c_INHIBIT_LAST) begin
                        r_cnt    <= '0;
                        r_dat_oe <= 1'b1;
                        r_state  <= S_RTS;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RTS: begin
                    if (r_cnt == c_RTS_LAST) begin
                        r_cnt    <= '0;
                        r_clk_oe <= 1'b0;
                        r_state  <= S_SEND;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_clk_fall) begin
                        r_cnt    <= '0;
                        r_dat_oe <= ~r_frame[r_bit_cnt];
                        if (r_bit_cnt == 4'd9) begin
                            r_state <= S_ACK;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    if (w_clk_fall) begin
                        r_cnt   <= '0;
                        r_nack  <= r_dat_sync;
                        r_state <= S_RELEASE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!w_release_done) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Completion and failure override whatever the state branch chose.
            if (w_retry) begin
                r_state   <= S_INHIBIT;
                r_cnt     <= '0;
                r_bit_cnt <= '0;
                r_clk_oe  <= 1'b1;
                r_dat_oe  <= 1'b0;
            end else if (w_fail || w_success) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_clk_oe <= 1'b0;
                r_dat_oe <= 1'b0;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_error  <= w_fail;
            end
        end
    end

    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_host_tx
// Brief    : Directed bench for ps2_host_tx with a wired-AND PS/2 device model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int c_INHIBIT = 20;
    localparam int c_RTS     = 4;
    localparam int c_TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       clk_oe, dat_oe, busy, done, error;
    logic       dev_clk_low, dev_dat_low;
    logic       w_clk_line, w_dat_line;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int inh_cnt = 0;
    int busy_fall_cnt = 0;
    logic       done_err = 1'b0;
    logic       done_busy = 1'b0;
    logic [1:0] done_oe = 2'b00;
    logic       inh_prev = 1'b0;
    logic       busy_prev = 1'b0;

    assign w_clk_line = ~(clk_oe | dev_clk_low);
    assign w_dat_line = ~(dat_oe | dev_dat_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(c_INHIBIT),
        .RTS_CYCLES    (c_RTS),
        .TIMEOUT_CYCLES(c_TIMEOUT)
    ) u_dut (
        .CLOCK_27  (clk),
        .reset     (rst),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .ps2_clk_in(w_clk_line),
        .ps2_dat_in(w_dat_line),
        .ps2_clk_oe(clk_oe),
        .ps2_dat_oe(dat_oe),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt  <= done_cnt + 1;
            done_err  <= error;
            done_busy <= busy;
            done_oe   <= {clk_oe, dat_oe};
            done_cyc  <= cyc;
        end
        if (clk_oe === 1'b1 && dat_oe === 1'b0 && !inh_prev) inh_cnt <= inh_cnt + 1;
        inh_prev <= (clk_oe === 1'b1 && dat_oe === 1'b0);
        if (busy === 1'b0 && busy_prev) busy_fall_cnt <= busy_fall_cnt + 1;
        busy_prev <= (busy === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    // Device: waits for request-to-send, then issues n_clk clock pulses (40-cycle period)
    // and records the line at each rising edge; the 11th pulse carries the ACK.
    task automatic dev_transfer(input int n_clk, input logic ack, output logic [10:0] bits);
        int guard;
        bits  = '0;
        guard = 0;
        while (!(clk_oe === 1'b0 && dat_oe === 1'b1) && guard < 2000) begin
            tick(1);
            guard++;
        end
        if (guard < 2000) begin
            tick(20);
            bits[0] = w_dat_line;
            for (int k = 1; k <= n_clk; k++) begin
                dev_clk_low   = 1'b1;
                last_fall_cyc = cyc;
                tick(20);
                dev_clk_low = 1'b0;
                if (k <= 10) bits[k] = w_dat_line;
                if (k == 10) dev_dat_low = ack;
                if (k == 11) dev_dat_low = 1'b0;
                if (k < n_clk) tick(20);
            end
        end
    endtask

    task automatic wait_done(input int prev);
        int guard;
        guard = 0;
        while (done_cnt == prev && guard < 1000) begin
            tick(1);
            guard++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (clk_oe !== 1'b0) begin n_bad++; $display("FAIL reset_clk_oe: got %b want 0", clk_oe); end
        n_cmp++; if (dat_oe !== 1'b0) begin n_bad++; $display("FAIL reset_dat_oe: got %b want 0", dat_oe); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", error); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_frame_ed();
        int prev, n_inh, n_rts, guard;
        logic [10:0] bits;
        prev = done_cnt;
        pulse_start(8'hED);
        @(negedge clk);
        n_inh = 0;
        guard = 0;
        while (clk_oe === 1'b1 && dat_oe === 1'b0 && guard < 100) begin
            n_inh++; guard++; @(negedge clk);
        end
        n_rts = 0;
        while (clk_oe === 1'b1 && dat_oe === 1'b1 && guard < 200) begin
            n_rts++; guard++; @(negedge clk);
        end
        n_cmp++; if (n_inh !== c_INHIBIT) begin n_bad++; $display("FAIL inhibit_len: got %0d want %0d", n_inh, c_INHIBIT); end
        n_cmp++; if (n_rts !== c_RTS) begin n_bad++; $display("FAIL rts_len: got %0d want %0d", n_rts, c_RTS); end
        n_cmp++; if ({clk_oe, dat_oe} !== 2'b01) begin n_bad++; $display("FAIL clk_release: got %b want 01", {clk_oe, dat_oe}); end
        @(posedge clk);
        #1;
        dev_transfer(11, 1'b1, bits);
        n_cmp++; if (bits !== 11'b11111011010) begin n_bad++; $display("FAIL frame_ed: got %b want 11111011010", bits); end
        wait_done(prev);
        n_cmp++; if (done_cnt - prev !== 1) begin n_bad++; $display("FAIL done_ed: got %0d pulses want 1", done_cnt - prev); end
        n_cmp++; if (done_err !== 1'b0) begin n_bad++; $display("FAIL error_ed: got %b want 0", done_err); end
        n_cmp++; if (done_busy !== 1'b0) begin n_bad++; $display("FAIL busy_at_done: got %b want 0", done_busy); end
        tick(5);
    endtask

    task automatic test_parity();
        logic [7:0]  vec_d [3];
        logic [10:0] vec_f [3];
        logic [10:0] bits;
        int prev;
        vec_d = '{8'hFF, 8'h00, 8'h01};
        vec_f = '{11'b11111111110, 11'b11000000000, 11'b10000000010};
        for (int i = 0; i < 3; i++) begin
            prev = done_cnt;
            pulse_start(vec_d[i]);
            dev_transfer(11, 1'b1, bits);
            n_cmp++; if (bits !== vec_f[i]) begin n_bad++; $display("FAIL frame_%h: got %b want %b", vec_d[i], bits, vec_f[i]); end
            wait_done(prev);
            n_cmp++; if (done_cnt - prev !== 1 || done_err !== 1'b0) begin
                n_bad++; $display("FAIL done_%h: got %0d pulses err %b want 1 pulse err 0", vec_d[i], done_cnt - prev, done_err);
            end
            tick(5);
        end
    endtask

    task automatic test_nack();
        logic [10:0] bits;
        int prev;
        prev = done_cnt;
        pulse_start(8'hF4);
        dev_transfer(11, 1'b0, bits);
`ifdef PS2_TX_RETRY_EN
        dev_transfer(11, 1'b0, bits);
`endif
        wait_done(prev);
        n_cmp++; if (done_cnt - prev !== 1) begin n_bad++; $display("FAIL done_nack: got %0d pulses want 1", done_cnt - prev); end
        n_cmp++; if (done_err !== 1'b1) begin n_bad++; $display("FAIL error_nack: got %b want 1", done_err); end
        tick(10);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL error_hold: got %b want 1", error); end
    endtask

    task automatic test_timeout();
        logic [10:0] bits;
        int prev, want;
`ifdef PS2_TX_RETRY_EN
        want = 2 * c_TIMEOUT + c_INHIBIT + c_RTS + 3;
`else
        want = c_TIMEOUT + 3;
`endif
        prev = done_cnt;
        pulse_start(8'hFF);
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL error_clear: got %b want 0", error); end
        dev_transfer(4, 1'b1, bits);
        wait_done(prev);
        n_cmp++; if (done_cnt - prev !== 1 || done_err !== 1'b1) begin
            n_bad++; $display("FAIL done_timeout: got %0d pulses err %b want 1 pulse err 1", done_cnt - prev, done_err);
        end
        // Pad fall to done: the 2-FF synchronizer and edge register add 3 cycles.
        n_cmp++; if (done_cyc - last_fall_cyc !== want) begin
            n_bad++; $display("FAIL timeout_latency: got %0d want %0d", done_cyc - last_fall_cyc, want);
        end
        n_cmp++; if (done_oe !== 2'b00) begin n_bad++; $display("FAIL timeout_release: got %b want 00", done_oe); end
        tick(5);
    endtask

    task automatic test_busy_ignore();
        logic [10:0] bits;
        int prev;
        prev = done_cnt;
        pulse_start(8'hED);
        tick(3);
        pulse_start(8'h12);
        dev_transfer(11, 1'b1, bits);
        n_cmp++; if (bits !== 11'b11111011010) begin n_bad++; $display("FAIL busy_ignore_frame: got %b want 11111011010", bits); end
        wait_done(prev);
        tick(50);
        n_cmp++; if (done_cnt - prev !== 1 || done_err !== 1'b0) begin
            n_bad++; $display("FAIL busy_ignore_done: got %0d pulses err %b want 1 pulse err 0", done_cnt - prev, done_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] bits;
        int prev;
        prev = done_cnt;
        pulse_start(8'h00);
        dev_transfer(3, 1'b1, bits);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if ({clk_oe, dat_oe, busy, done} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_mid: got clk_oe/dat_oe/busy/done %b want 0000", {clk_oe, dat_oe, busy, done});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(3);
        n_cmp++; if (done_cnt !== prev) begin n_bad++; $display("FAIL reset_mid_done: got %0d pulses want 0", done_cnt - prev); end
        pulse_start(8'hFF);
        dev_transfer(11, 1'b1, bits);
        n_cmp++; if (bits !== 11'b11111111110) begin n_bad++; $display("FAIL after_reset_frame: got %b want 11111111110", bits); end
        wait_done(prev);
        n_cmp++; if (done_cnt - prev !== 1 || done_err !== 1'b0) begin
            n_bad++; $display("FAIL after_reset_done: got %0d pulses err %b want 1 pulse err 0", done_cnt - prev, done_err);
        end
        tick(5);
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits;
        int prev, guard;
        prev = done_cnt;
        pulse_start(8'h00);
        dev_transfer(11, 1'b1, bits);
        n_cmp++; if (bits !== 11'b11000000000) begin n_bad++; $display("FAIL b2b_frame_00: got %b want 11000000000", bits); end
        tx_data  = 8'h01;
        tx_start = 1'b1;
        guard    = 0;
        @(negedge clk);
        while (done !== 1'b1 && guard < 200) begin
            guard++; @(negedge clk);
        end
        n_cmp++; if ({done, busy, error} !== 3'b100) begin
            n_bad++; $display("FAIL b2b_done: got done/busy/error %b want 100", {done, busy, error});
        end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_start_on_done: got busy %b want 0", busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_next: got busy %b want 1", busy); end
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        dev_transfer(11, 1'b1, bits);
        n_cmp++; if (bits !== 11'b10000000010) begin n_bad++; $display("FAIL b2b_frame_01: got %b want 10000000010", bits); end
        wait_done(prev + 1);
        n_cmp++; if (done_cnt - prev !== 2 || done_err !== 1'b0) begin
            n_bad++; $display("FAIL b2b_count: got %0d pulses err %b want 2 pulses err 0", done_cnt - prev, done_err);
        end
        tick(5);
    endtask

`ifdef PS2_TX_RETRY_EN
    task automatic test_retry();
        logic [10:0] bits;
        int prev, prev_inh, prev_bf;
        prev     = done_cnt;
        prev_inh = inh_cnt;
        prev_bf  = busy_fall_cnt;
        pulse_start(8'hF4);
        dev_transfer(11, 1'b0, bits);
        n_cmp++; if (bits !== 11'b10111101000) begin n_bad++; $display("FAIL retry_frame1: got %b want 10111101000", bits); end
        dev_transfer(11, 1'b1, bits);
        n_cmp++; if (bits !== 11'b10111101000) begin n_bad++; $display("FAIL retry_frame2: got %b want 10111101000", bits); end
        wait_done(prev);
        tick(5);
        n_cmp++; if (done_cnt - prev !== 1 || done_err !== 1'b0) begin
            n_bad++; $display("FAIL retry_done: got %0d pulses err %b want 1 pulse err 0", done_cnt - prev, done_err);
        end
        n_cmp++; if (inh_cnt - prev_inh !== 2) begin n_bad++; $display("FAIL retry_inhibits: got %0d want 2", inh_cnt - prev_inh); end
        n_cmp++; if (busy_fall_cnt - prev_bf !== 1) begin n_bad++; $display("FAIL retry_busy: got %0d busy drops want 1", busy_fall_cnt - prev_bf); end
    endtask
`endif

    initial begin
        rst         = 1'b1;
        tx_start    = 1'b0;
        tx_data     = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        tick(5);
        test_reset();
        test_frame_ed();
        test_parity();
        test_nack();
        test_timeout();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
`ifdef PS2_TX_RETRY_EN
        test_retry();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
